tnn_feature_quantizer: RTL and testbench

// - Front-end stage for the 2-bit-per-feature approximate TNN classifiers (8 features, 16-bit input).
// - Accepts raw features one per beat on a valid/ready stream and quantizes each to 2 bits by thresholds.
// - Packs the 8 quantized features into one vector and presents it downstream with valid/ready.
// - Output drives the classifier's input_a..input_h directly.

---
 rtl/tnn_pkg.sv | 23 ++
 rtl/tnn_thr_quant.sv | 16 +
 rtl/tnn_feature_quantizer.sv | 107 ++++++++++
 tb/tb_tnn_feature_quantizer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types and helpers for the TNN feature front-end: state encoding,
// vector geometry and the 2-bit threshold quantizer.
package tnn_pkg;

  localparam int N_FEAT = 8;
  localparam int Q_W    = 2;

  typedef enum logic [1:0] {COLLECT, HOLD, DRAIN} fq_state_t;

  // Arguments are zero-extended to 16 bits so any RAW_W up to 16 can share this helper.
  function automatic logic [Q_W-1:0] quant2(input logic [15:0] x,
                                            input logic [15:0] lo,
                                            input logic [15:0] mid,
                                            input logic [15:0] hi);
    logic [Q_W-1:0] q;
    if (x >= hi)       q = 2'd3;
    else if (x >= mid) q = 2'd2;
    else if (x >= lo)  q = 2'd1;
    else               q = 2'd0;
    return q;
  endfunction

endpackage

// File: rtl/tnn_thr_quant.sv
// Combinational unsigned threshold comparator mapping one raw feature to 2 bits.
module tnn_thr_quant
  import tnn_pkg::*;
#(
  parameter int               RAW_W   = 8,
  parameter logic [RAW_W-1:0] THR_LO  = 8'd64,
  parameter logic [RAW_W-1:0] THR_MID = 8'd128,
  parameter logic [RAW_W-1:0] THR_HI  = 8'd192
) (
  input  logic [RAW_W-1:0] x,
  output logic [Q_W-1:0]   q
);

  assign q = quant2(16'(x), 16'(THR_LO), 16'(THR_MID), 16'(THR_HI));

endmodule

// File: rtl/tnn_feature_quantizer.sv
// Collects 8 raw features from a stream, quantizes each to 2 bits and hands the
// packed vector to the classifier; malformed vectors are dropped with err_len.
module tnn_feature_quantizer
  import tnn_pkg::*;
#(
  parameter int               RAW_W   = 8,
  parameter logic [RAW_W-1:0] THR_LO  = 8'd64,
  parameter logic [RAW_W-1:0] THR_MID = 8'd128,
  parameter logic [RAW_W-1:0] THR_HI  = 8'd192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [RAW_W-1:0]      s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [N_FEAT*Q_W-1:0] m_feat,
  output logic                  err_len,
  output logic [15:0]           vec_cnt
);

  if (!((THR_LO <= THR_MID) && (THR_MID <= THR_HI))) begin : g_thr_order_check
    $error("tnn_feature_quantizer: thresholds must satisfy THR_LO <= THR_MID <= THR_HI");
  end

  fq_state_t             state;
  logic [2:0]            idx;
  logic [N_FEAT*Q_W-1:0] shadow;
  logic [N_FEAT*Q_W-1:0] shadow_next;
  logic [Q_W-1:0]        q;
  logic                  accept;

  tnn_thr_quant #(
    .RAW_W   (RAW_W),
    .THR_LO  (THR_LO),
    .THR_MID (THR_MID),
    .THR_HI  (THR_HI)
  ) u_quant (
    .x (s_data),
    .q (q)
  );

  // s_ready comes straight from the state register, so no s_* -> m_* path exists.
  assign s_ready = (state != HOLD);
  assign accept  = s_valid && s_ready;

  always_comb begin
    shadow_next = shadow;
    shadow_next[{idx, 1'b0} +: Q_W] = q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      idx     <= 3'd0;
      shadow  <= '0;
      m_valid <= 1'b0;
      m_feat  <= '0;
      err_len <= 1'b0;
      vec_cnt <= 16'd0;
    end else begin
      err_len <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            shadow <= shadow_next;
            if (idx == 3'd7) begin
              idx <= 3'd0;
              if (s_last) begin
                m_feat  <= shadow_next;
                m_valid <= 1'b1;
                state   <= HOLD;
              end else begin
                // Too many beats: flag once, then swallow the rest up to s_last.
                err_len <= 1'b1;
                state   <= DRAIN;
              end
            end else if (s_last) begin
              idx     <= 3'd0;
              err_len <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            idx     <= 3'd0;
            state   <= COLLECT;
            if (vec_cnt != 16'hFFFF) vec_cnt <= vec_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (accept && s_last) begin
            idx   <= 3'd0;
            state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_feature_quantizer.sv
// Directed + randomized bench for tnn_feature_quantizer against a vector-level
// reference model (threshold counting and length classification).
module tb_tnn_feature_quantizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_feat;
  logic        err_len;
  logic [15:0] vec_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [7:0]  vq[$];
  logic [7:0]  edge_vals[8] = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};

  tnn_feature_quantizer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_feat  (m_feat),
    .err_len (err_len),
    .vec_cnt (vec_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && err_len) err_seen++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference quantizer: number of thresholds (64,128,192) the value reaches.
  function automatic logic [1:0] ref_q(input logic [7:0] x);
    int n;
    n = 0;
    if (int'(x) >= 64)  n++;
    if (int'(x) >= 128) n++;
    if (int'(x) >= 192) n++;
    return 2'(n);
  endfunction

  function automatic logic [15:0] ref_pack();
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[2*i +: 2] = ref_q(vq[i]);
    return p;
  endfunction

  function automatic logic [7:0] rand_val();
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 7)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("s_ready_before_beat", {15'b0, s_ready}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_vec();
    for (int i = 0; i < vq.size(); i++) send_beat(vq[i], (i == vq.size() - 1));
    if (vq.size() != 8) exp_err++;
  endtask

  task automatic fill_rand(input int len);
    vq.delete();
    for (int i = 0; i < len; i++) vq.push_back(rand_val());
  endtask

  // Called on the negedge right after the 8th beat was accepted.
  task automatic take_vec(input logic [15:0] expv, input int stall);
    check("m_valid_latency", {15'b0, m_valid}, 16'd1);
    check("m_feat", m_feat, expv);
    for (int c = 0; c < stall; c++) begin
      m_ready = 1'b0;
      @(negedge clk);
      check("bp_m_feat_stable", m_feat, expv);
      check("bp_s_ready_low", {15'b0, s_ready}, 16'd0);
      check("bp_m_valid_high", {15'b0, m_valid}, 16'd1);
    end
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    check("post_hs_m_valid", {15'b0, m_valid}, 16'd0);
    check("post_hs_s_ready", {15'b0, s_ready}, 16'd1);
    check("vec_cnt", vec_cnt, exp_cnt);
    check("err_count", 16'(err_seen), 16'(exp_err));
  endtask

  task automatic check_dropped();
    idle(2);
    check("drop_no_m_valid", {15'b0, m_valid}, 16'd0);
    check("drop_err_count", 16'(err_seen), 16'(exp_err));
    check("drop_vec_cnt", vec_cnt, exp_cnt);
  endtask

  initial begin
    int len;
    int snap_err;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'd0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    idle(3);
    check("rst_m_valid", {15'b0, m_valid}, 16'd0);
    check("rst_m_feat", m_feat, 16'd0);
    check("rst_err_len", {15'b0, err_len}, 16'd0);
    check("rst_vec_cnt", vec_cnt, 16'd0);
    rst_n = 1'b1;
    idle(1);
    check("rst_s_ready", {15'b0, s_ready}, 16'd1);

    $display("[TB] happy path");
    vq = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};
    send_vec();
    check("happy_const", m_feat, 16'hFA50);
    take_vec(ref_pack(), 0);

    $display("[TB] backpressure");
    fill_rand(8);
    send_vec();
    take_vec(ref_pack(), 5);

    $display("[TB] short vector");
    fill_rand(3);
    send_vec();
    check_dropped();
    fill_rand(8);
    send_vec();
    take_vec(ref_pack(), 1);

    $display("[TB] long vector");
    fill_rand(10);
    for (int i = 0; i < 10; i++) begin
      send_beat(vq[i], (i == 9));
      if (i == 7) check("long_err_at_beat8", {15'b0, err_len}, 16'd1);
    end
    exp_err++;
    check_dropped();
    fill_rand(8);
    send_vec();
    take_vec(ref_pack(), 2);

    $display("[TB] random vectors");
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    len = 8;
        2:       len = $urandom_range(1, 7);
        default: len = $urandom_range(9, 12);
      endcase
      fill_rand(len);
      send_vec();
      if (len == 8) take_vec(ref_pack(), $urandom_range(0, 3));
      else          check_dropped();
    end

    $display("[TB] reset mid-vector");
    fill_rand(4);
    for (int i = 0; i < 4; i++) send_beat(vq[i], 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    idle(1);
    check("midrst_vec_cnt", vec_cnt, 16'd0);
    check("midrst_m_valid", {15'b0, m_valid}, 16'd0);
    snap_err = err_seen;
    vq.delete();
    for (int i = 0; i < 8; i++) vq.push_back(8'd200);
    send_vec();
    check("midrst_feat_ffff", m_feat, 16'hFFFF);
    take_vec(ref_pack(), 0);
    check("midrst_no_err", 16'(err_seen), 16'(snap_err));

    $display("[TB] vec_cnt saturation");
    force dut.vec_cnt = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    fill_rand(8);
    send_vec();
    take_vec(ref_pack(), 0);
    release dut.vec_cnt;
    idle(1);
    check("sat_after_release", vec_cnt, 16'hFFFF);
    fill_rand(8);
    send_vec();
    take_vec(ref_pack(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
